// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encodings and prescaler helper for the LED sequencer
package led_seq_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/led_seq_channel.sv
// rtl/led_seq_channel.sv - one LED channel: mode, half-period, ms counter, phase, lit
// Triangle-wave PWM duty for BREATHE only when LED_SEQ_BREATHE_EN is defined.
module led_seq_channel
  import led_seq_pkg::*;
#(
  parameter int PW         = 16,
  parameter int DEF_PERIOD = 500,
  parameter bit INIT_PHASE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          wr,
  input  logic [1:0]    wr_mode,
  input  logic [PW-1:0] wr_period,
`ifdef LED_SEQ_BREATHE_EN
  input  logic [7:0]    pwm_cnt,
`endif
  output logic          lit
);

  logic [1:0]    mode;
  logic [PW-1:0] period;
  logic [PW-1:0] ms_cnt;
  logic [PW-1:0] last_cnt;
  logic          phase;
  logic          wrap;
  logic          toggles;

  // A period of 0 behaves as 1; >= keeps the counter bounded whatever the history.
  assign last_cnt = (period == '0) ? '0 : period - PW'(1);
  assign wrap     = tick && (ms_cnt >= last_cnt);

`ifdef LED_SEQ_BREATHE_EN
  assign toggles = (mode == MODE_BLINK);
`else
  assign toggles = mode[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= MODE_BLINK;
      period <= PW'(DEF_PERIOD);
      ms_cnt <= '0;
      phase  <= INIT_PHASE;
    end else if (wr) begin
      mode   <= wr_mode;
      period <= wr_period;
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= wrap ? '0 : ms_cnt + PW'(1);
      if (wrap && toggles) phase <= ~phase;
    end
  end

`ifdef LED_SEQ_BREATHE_EN
  logic [7:0] duty;
  logic       duty_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty    <= 8'd0;
      duty_up <= 1'b1;
    end else if (wr) begin
      if (wr_mode == MODE_BREATHE && mode != MODE_BREATHE) begin
        duty    <= 8'd0;
        duty_up <= 1'b1;
      end
    end else if (wrap && mode == MODE_BREATHE) begin
      if (duty_up && duty == 8'd255) begin
        duty_up <= 1'b0;
        duty    <= 8'd254;
      end else if (!duty_up && duty == 8'd0) begin
        duty_up <= 1'b1;
        duty    <= 8'd1;
      end else begin
        duty    <= duty_up ? duty + 8'd1 : duty - 8'd1;
      end
    end
  end
`endif

  always_comb begin
    lit = 1'b0;
    case (mode)
      MODE_OFF:   lit = 1'b0;
      MODE_ON:    lit = 1'b1;
      MODE_BLINK: lit = phase;
`ifdef LED_SEQ_BREATHE_EN
      default:    lit = (pwm_cnt < duty);
`else
      default:    lit = phase;
`endif
    endcase
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - N-channel LED sequencer: 1 ms prescaler, write decode, output register
// Optional BREATHE PWM (pwm_cnt) enabled by LED_SEQ_BREATHE_EN.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int  N_CH       = 2,
  parameter int  CLK_HZ     = 100000000,
  parameter int  PW         = 16,
  parameter int  DEF_PERIOD = 500,
  parameter int  ACTIVE_LOW = 0,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_ch,
  input  logic [1:0]      wr_mode,
  input  logic [PW-1:0]   wr_period,
  output logic [N_CH-1:0] led_o,
  output logic            tick_o
);

  localparam int DIV = ms_div(CLK_HZ);
  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;

  function automatic logic [N_CH-1:0] odd_bits();
    logic [N_CH-1:0] m;
    m = '0;
    for (int k = 1; k < N_CH; k += 2) m[k] = 1'b1;
    return m;
  endfunction

  localparam logic [N_CH-1:0] POL     = {N_CH{ACTIVE_LOW != 0}};
  localparam logic [N_CH-1:0] RST_LED = odd_bits() ^ POL;

  logic [PCW-1:0]  presc;
  logic [N_CH-1:0] lit;

  // Decoded from the count so reset removes the strobe without waiting for an edge.
  assign tick_o = (presc == PCW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      presc <= '0;
    else if (tick_o) presc <= '0;
    else             presc <= presc + PCW'(1);
  end

`ifdef LED_SEQ_BREATHE_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= 8'd0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end
`endif

  // Channels beyond N_CH do not exist, so out-of-range writes match nothing.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_seq_channel #(
      .PW         (PW),
      .DEF_PERIOD (DEF_PERIOD),
      .INIT_PHASE (i % 2 == 1)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_o),
      .wr        (wr_en && (wr_ch == CW'(i))),
      .wr_mode   (wr_mode),
      .wr_period (wr_period),
`ifdef LED_SEQ_BREATHE_EN
      .pwm_cnt   (pwm_cnt),
`endif
      .lit       (lit[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_o <= RST_LED;
    else        led_o <= lit ^ POL;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - randomized self-checking bench for led_sequencer against a time-based model
module tb_led_sequencer;

  localparam int N      = 4;
  localparam int CLK_HZ = 10000;
  localparam int PW     = 16;
  localparam int DEFP   = 3;
  localparam int MS     = CLK_HZ / 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [1:0]    wr_mode = '0;
  logic [PW-1:0] wr_period = '0;
  logic [3:0]    led, led_al;
  logic [2:0]    led3;
  logic          tick, tick_al, tick3;

  always #5 clk = ~clk;

  led_sequencer #(.N_CH(N), .CLK_HZ(CLK_HZ), .PW(PW), .DEF_PERIOD(DEFP), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .led_o(led), .tick_o(tick));

  led_sequencer #(.N_CH(N), .CLK_HZ(CLK_HZ), .PW(PW), .DEF_PERIOD(DEFP), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .led_o(led_al), .tick_o(tick_al));

  led_sequencer #(.N_CH(3), .CLK_HZ(CLK_HZ), .PW(PW), .DEF_PERIOD(DEFP), .ACTIVE_LOW(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .led_o(led3), .tick_o(tick3));

  int errors = 0;
  int checks = 0;
  int ecount = 0;

  // Model: each channel remembers the edge of its last write and the phase/duty position
  // at that moment; everything later follows from the number of 1 ms ticks since then.
  int m_mode[N], m_per[N], m_w[N], m_base[N], m_pos[N];
  logic [3:0] exp_q;
  logic       exp_tick;

  function automatic int eff(int ch);
    return (m_per[ch] == 0) ? 1 : m_per[ch];
  endfunction

  function automatic int wraps(int ch, int e);
    return (e / MS - m_w[ch] / MS) / eff(ch);
  endfunction

  function automatic bit blinkish(int md);
`ifdef LED_SEQ_BREATHE_EN
    return md == 2;
`else
    return md >= 2;
`endif
  endfunction

  function automatic int phase_at(int ch, int e);
    if (blinkish(m_mode[ch])) return m_base[ch] ^ (wraps(ch, e) & 1);
    return m_base[ch];
  endfunction

  function automatic int pos_at(int ch, int e);
    if (m_mode[ch] == 3) return (m_pos[ch] + wraps(ch, e)) % 510;
    return m_pos[ch];
  endfunction

  function automatic int duty_of(int p);
    return (p <= 255) ? p : 510 - p;
  endfunction

  function automatic bit lit_at(int ch, int e);
    case (m_mode[ch])
      0: return 1'b0;
      1: return 1'b1;
      2: return phase_at(ch, e) != 0;
`ifdef LED_SEQ_BREATHE_EN
      default: return (e % 256) < duty_of(pos_at(ch, e));
`else
      default: return phase_at(ch, e) != 0;
`endif
    endcase
  endfunction

  function automatic logic [3:0] exp_led(int e);
    logic [3:0] v;
    v = 4'b1010;
    if (e > 0)
      for (int ch = 0; ch < N; ch++) v[ch] = lit_at(ch, e - 1);
    return v;
  endfunction

  function automatic logic [13:0] exp_vec();
    return {exp_q, ~exp_q, exp_q[2:0], {3{exp_tick}}};
  endfunction

  function automatic logic [13:0] act_vec();
    return {led, led_al, led3, tick, tick_al, tick3};
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_mode[ch] = 2; m_per[ch] = DEFP; m_w[ch] = 0; m_base[ch] = ch % 2; m_pos[ch] = 0;
    end
    ecount = 0;
    exp_q = 4'b1010;
    exp_tick = 1'b0;
  endtask

  task automatic apply_write(int ch, int md, int pr, int e);
    int ph;
    int ps;
    ph = phase_at(ch, e - 1);
    ps = pos_at(ch, e - 1);
    if (md == 3 && m_mode[ch] != 3) ps = 0;
    m_base[ch] = ph; m_pos[ch] = ps; m_mode[ch] = md; m_per[ch] = pr; m_w[ch] = e;
  endtask

  task automatic step();
    bit pend = wr_en;
    int ch = wr_ch;
    int md = wr_mode;
    int pr = wr_period;
    @(posedge clk);
    ecount++;
    exp_q = exp_led(ecount);
    exp_tick = (ecount % MS == MS - 1);
    if (pend) apply_write(ch, md, pr, ecount);
    #1;
  endtask

  task automatic do_write(int ch, int md, int pr);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_mode = 2'(md); wr_period = PW'(pr);
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (act_vec() !== 14'b1010_0101_010_000) begin
      errors++; $display("FAIL reset_state: got %b expected %b", act_vec(), 14'b1010_0101_010_000);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_blink();
    for (int n = 0; n < 70; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL blink e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
      if (ecount == 31) begin
        checks++;
        if (led !== 4'b0101) begin
          errors++; $display("FAIL blink_first_toggle: got %b expected 0101", led);
        end
      end
    end
  endtask

  task automatic test_write_on();
    do_write(2, 1, 3);
    step();
    checks++;
    if (led[2] !== 1'b1) begin
      errors++; $display("FAIL write_on_latency: got %b expected 1", led[2]);
    end
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec() || led[2] !== 1'b1) begin
        errors++; $display("FAIL write_on e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_period_zero();
    do_write(1, 2, 0);
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL period_zero e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ignored_and_tick_write();
    do_write(3, 0, 5);
    for (int n = 0; n < 25; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL ignored_write e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
    do_write(2, 2, 2);
    while ((ecount + 1) % MS != 0) step();
    do_write(2, 2, 1);
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL tick_write e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      int gap = $urandom_range(0, 15);
      for (int n = 0; n < gap; n++) begin
        step();
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++; $display("FAIL random e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
        end
      end
      do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_wr e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (ecount % MS != MS - 1 && guard < 100) begin step(); guard++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act_vec() !== 14'b1010_0101_010_000) begin
      errors++; $display("FAIL async_reset: got %b expected %b", act_vec(), 14'b1010_0101_010_000);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 35; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL after_reset e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
  endtask

`ifdef LED_SEQ_BREATHE_EN
  task automatic test_breathe();
    do_write(0, 3, 1);
    for (int n = 0; n < 6000; n++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL breathe e=%0d: got %b expected %b", ecount, act_vec(), exp_vec());
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_blink();
    test_write_on();
    test_period_zero();
    test_ignored_and_tick_write();
    test_random();
    test_async_reset();
`ifdef LED_SEQ_BREATHE_EN
    test_breathe();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
